mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator sitting between the execute stage and `Data_Memory`. It accepts one LDUR/STUR request at a time over a valid/ready handshake and forms the byte address as base + sign-extended 9-bit offset. It checks alignment and range, drives the memory's single-port write/read enables for exactly one cycle, and captures the registered read data. It returns a result or fault over a second valid/ready handshake.

## Interface
- `ADDRSIZE`, 64: data and address width.
- `MEMSIZE`, 64: number of 64-bit words in the attached memory; legal word index 0..MEMSIZE-1.
- `clk` input 1: single clock, all state changes on posedge.
- `rst` input 1: synchronous, active-low reset (rst==0 resets at posedge).
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_is_store` input 1: 1 = STUR, 0 = LDUR.
- `req_base` input ADDRSIZE: base register value (byte address).
- `req_offset` input 9: signed byte offset (two's complement).
- `req_wdata` input ADDRSIZE: store data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_rdata` output ADDRSIZE: load data; 0 for stores and faults.
- `rsp_fault` output 2: 00 ok, 01 misaligned, 10 out of range (misaligned wins if both apply).
- `MemAddress` output ADDRSIZE: word index to memory.
- `MemWriteData` output ADDRSIZE: data to memory.
- `MemWriteEnable` output 1: write strobe.
- `MemReadEnable` output 1: read strobe.
- `MemReadData` input ADDRSIZE: memory read data, valid the cycle after a read strobe edge.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch is_store and wdata; compute `addr = req_base + sext64(req_offset)` modulo 2^64; go to ISSUE.
  - `MemAddress <= addr >> 3`.
  - `fault`: misaligned if `addr[2:0]!=0`, else out of range if `(addr>>3) >= MEMSIZE`.
- ISSUE:
  - If fault: no strobe; go to RESP with `rsp_rdata`=0.
  - Else if store: `MemWriteEnable`=1 for this cycle only; go to RESP.
  - Else: `MemReadEnable`=1 for this cycle only; go to WAIT.
- WAIT: `rsp_rdata <= MemReadData`; go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata` and `rsp_fault` are held stable.
  - When `rsp_ready`=1, go to IDLE.
  - `rsp_ready` is ignored outside RESP.
- Strobes are decoded from state and latched type and are never both high. Both strobes are forced to 0 whenever `rst`==0, including combinationally during a reset cycle.
- `MemAddress` and `MemWriteData` hold their last value outside ISSUE.
- Address arithmetic wraps silently. The wrapped result is then range-checked, so a negative effective address faults as out of range.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=00, `MemAddress`=0, `MemWriteData`=0, both strobes 0.
- Accept at edge E0 (`req_valid`&`req_ready`). ISSUE occupies cycle E0..E1.
  - Store and fault: `rsp_valid` rises after E1, a latency of 2 cycles.
  - Load: `rsp_valid` rises after E2, a latency of 3 cycles.
- Store data is committed in memory at E1. A load issued in the cycle after a store's RESP handshake sees the new data.
- Throughput: at most one request in flight. Peak rate is one request per 3 cycles (store) or 4 cycles (load) with `rsp_ready` held high.
- `req_ready`=0 in ISSUE, WAIT and RESP. A `req_valid` asserted there is not consumed and must be held by the producer.
- Back-pressure: `rsp_valid` stays high indefinitely until `rsp_ready`. No new request is accepted until the edge after the handshake.
- Reset mid-operation in any state: returns to IDLE with reset values at that edge. The in-flight request is dropped with no response, and no strobe is seen by memory during the reset cycle.

## Test plan
- Reset, then store base=0x10, offset=+8, wdata=0xDEADBEEF_CAFEF00D: `MemWriteEnable` high for exactly 1 cycle with `MemAddress`=3. `rsp_valid` 2 cycles after accept with `rsp_fault`=00 and `rsp_rdata`=0.
- Load base=0x20, offset=-8, following the previous store: `MemReadEnable` for 1 cycle with `MemAddress`=3. `rsp_rdata`=0xDEADBEEF_CAFEF00D with `rsp_fault`=00, 3 cycles after accept.
- Misaligned load base=0x8, offset=+4: `rsp_fault`=01, no strobe on either enable, `rsp_rdata`=0. Out-of-range store base=0x200 (index 64): `rsp_fault`=10 and memory is untouched. base=0, offset=-8 gives `rsp_fault`=10.
- Hold `rsp_ready`=0 for 5 cycles after a load response: `rsp_valid` and `rsp_rdata` remain stable, `req_ready`=0, and a pending `req_valid` is not accepted until the cycle after `rsp_ready`=1.
- Drive `rst`=0 during ISSUE of a store to index 5: both enables are 0 in that cycle, word 5 remains at its prior value, and all outputs equal the reset values after the edge.
- Back-to-back requests with `req_valid` and `rsp_ready` held high: accept edges are spaced 3 cycles apart (store) and 4 cycles apart (load), and strobes never overlap.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake plus the single-port data memory bus of the load/store unit
interface mem_access_if #(parameter int ADDRSIZE = 64);
    logic                req_valid;
    logic                req_ready;
    logic                req_is_store;
    logic [ADDRSIZE-1:0] req_base;
    logic [8:0]          req_offset;
    logic [ADDRSIZE-1:0] req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ADDRSIZE-1:0] rsp_rdata;
    logic [1:0]          rsp_fault;
    logic [ADDRSIZE-1:0] MemAddress;
    logic [ADDRSIZE-1:0] MemWriteData;
    logic                MemWriteEnable;
    logic                MemReadEnable;
    logic [ADDRSIZE-1:0] MemReadData;
    modport master (
        output req_valid, req_is_store, req_base, req_offset, req_wdata, rsp_ready, MemReadData,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, MemAddress, MemWriteData, MemWriteEnable, MemReadEnable
    );
    modport slave (
        input  req_valid, req_is_store, req_base, req_offset, req_wdata, rsp_ready, MemReadData,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, MemAddress, MemWriteData, MemWriteEnable, MemReadEnable
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time LDUR/STUR initiator with alignment/range checks in front of Data_Memory
module mem_access_unit #(
    parameter int ADDRSIZE = 64,
    parameter int MEMSIZE  = 64
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [ADDRSIZE-1:0] WORDS = ADDRSIZE'(MEMSIZE);
    state_t              state;
    logic                is_store;
    logic                issue_ok;
    logic [1:0]          fault;
    logic [ADDRSIZE-1:0] addr;
    logic [ADDRSIZE-1:0] rdata;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [ADDRSIZE-1:0] mem_wdata;
    assign addr = bus.req_base + {{(ADDRSIZE-9){bus.req_offset[8]}}, bus.req_offset};
    // strobes are gated by rst so memory never sees one during a reset cycle
    assign issue_ok           = rst && state == ISSUE && fault == 2'b00;
    assign bus.MemWriteEnable = issue_ok && is_store;
    assign bus.MemReadEnable  = issue_ok && !is_store;
    assign bus.req_ready      = state == IDLE;
    assign bus.rsp_valid      = state == RESP;
    assign bus.rsp_rdata      = rdata;
    assign bus.rsp_fault      = fault;
    assign bus.MemAddress     = mem_addr;
    assign bus.MemWriteData   = mem_wdata;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            fault     <= 2'b00;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    state     <= ISSUE;
                    is_store  <= bus.req_is_store;
                    mem_wdata <= bus.req_wdata;
                    mem_addr  <= addr >> 3;
                    rdata     <= '0;
                    fault     <= addr[2:0] != 3'b000 ? 2'b01 : (addr >> 3) >= WORDS ? 2'b10 : 2'b00;
                end
                ISSUE: state <= (fault == 2'b00 && !is_store) ? WAIT : RESP;
                WAIT: begin
                    rdata <= bus.MemReadData;
                    state <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a word-array reference model and a behavioural Data_Memory
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mem_access_if #(.ADDRSIZE(64)) bus ();
    mem_access_unit #(.ADDRSIZE(64), .MEMSIZE(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    typedef struct {
        logic        st;
        logic [1:0]  fault;
        logic [63:0] rdata;
        logic [63:0] idx;
        logic [63:0] wdata;
        int          acc;
    } exp_t;
    exp_t        q[$];
    logic [63:0] mem_arr[64];
    logic [63:0] ref_mem[64];
    logic [63:0] rd_reg;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_we = 0;
    int          n_re = 0;
    bit          seen = 1'b0;
    bit          rnd_bp = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    // Data_Memory: synchronous write, registered read
    always @(posedge clk) begin
        if (bus.MemWriteEnable && bus.MemAddress < 64) mem_arr[bus.MemAddress[5:0]] <= bus.MemWriteData;
        if (bus.MemReadEnable) rd_reg <= mem_arr[bus.MemAddress[5:0]];
    end
    assign bus.MemReadData = rd_reg;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Reference: effective address from plain signed arithmetic, words kept in an array
    function automatic exp_t model(logic st, logic [63:0] base, logic [8:0] off, logic [63:0] wd, int acc);
        exp_t e;
        longint so = longint'($signed(off));
        logic [63:0] ea = base + 64'(so);
        e.st = st;
        e.wdata = wd;
        e.acc = acc;
        e.idx = ea / 8;
        e.rdata = 64'd0;
        e.fault = (ea % 8 != 0) ? 2'd1 : (ea / 8 >= 64) ? 2'd2 : 2'd0;
        if (e.fault == 2'd0) begin
            if (st) ref_mem[e.idx[5:0]] = wd;
            else e.rdata = ref_mem[e.idx[5:0]];
        end
        return e;
    endfunction
    // Leaves req_valid high so callers can chain requests back to back
    task automatic do_req(input logic st, input logic [63:0] base, input logic [8:0] off,
                          input logic [63:0] wd, output int acc);
        bit ok = 1'b0;
        bus.req_is_store = st;
        bus.req_base = base;
        bus.req_offset = off;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
        else begin
            @(posedge clk);
            #1;
            acc = cyc;
            q.push_back(model(st, base, off, wd, acc));
        end
    endtask
    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic check_reset();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        chk("rst_mem_addr", bus.MemAddress, 64'd0);
        chk("rst_mem_wdata", bus.MemWriteData, 64'd0);
        chk("rst_we", 64'(bus.MemWriteEnable), 64'd0);
        chk("rst_re", 64'(bus.MemReadEnable), 64'd0);
    endtask
    always @(negedge clk) if (rst) begin
        if (bus.MemWriteEnable || bus.MemReadEnable) begin
            chk("strobe_overlap", 64'(bus.MemWriteEnable & bus.MemReadEnable), 64'd0);
            if (q.size() == 0) chk("strobe_unexpected", 64'(bus.MemWriteEnable | bus.MemReadEnable), 64'd0);
            else begin
                chk("mem_addr", bus.MemAddress, q[0].idx);
                if (bus.MemWriteEnable) chk("mem_wdata", bus.MemWriteData, q[0].wdata);
            end
            n_we += int'(bus.MemWriteEnable);
            n_re += int'(bus.MemReadEnable);
        end
        if (bus.rsp_valid) begin
            if (q.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - q[0].acc + 1), (q[0].st || q[0].fault != 2'd0) ? 64'd2 : 64'd3);
                    chk("we_count", 64'(n_we), 64'(q[0].st && q[0].fault == 2'd0));
                    chk("re_count", 64'(n_re), 64'(!q[0].st && q[0].fault == 2'd0));
                    n_we = 0;
                    n_re = 0;
                end
                chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                chk("rsp_fault", 64'(bus.rsp_fault), 64'(q[0].fault));
                if (bus.rsp_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int a0, a1, a2, l0, l1, l2, hs, b;
        logic [63:0] hold_d, old5;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = {$urandom, $urandom};
            ref_mem[i] = mem_arr[i];
        end
        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_base = '0;
        bus.req_offset = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        do_req(1'b1, 64'h10, 9'd8, 64'hDEADBEEF_CAFEF00D, a0);
        do_req(1'b0, 64'h20, 9'h1F8, 64'd0, a1);
        bus.req_valid = 1'b0;
        drain();
        chk("store_then_load_rdata", ref_mem[3], 64'hDEADBEEF_CAFEF00D);
        do_req(1'b0, 64'h8, 9'd4, 64'd0, a0);
        do_req(1'b1, 64'h200, 9'd0, 64'h5555, a1);
        do_req(1'b0, 64'h0, 9'h1F8, 64'd0, a2);
        bus.req_valid = 1'b0;
        drain();
        do_req(1'b0, 64'h40, 9'd0, 64'd0, a0);
        bus.rsp_ready = 1'b0;
        hs = 0;
        fork
            do_req(1'b1, 64'h48, 9'd0, 64'h1234_5678_9ABC_DEF0, b);
            begin
                for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
                hold_d = bus.rsp_rdata;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                    chk("hold_rsp_rdata", bus.rsp_rdata, hold_d);
                    chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
                end
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
                hs = cyc + 1;
            end
        join
        chk("hold_accept_cycle", 64'(b), 64'(hs + 1));
        bus.req_valid = 1'b0;
        drain();
        do_req(1'b1, 64'h50, 9'd0, 64'hA, a0);
        do_req(1'b1, 64'h58, 9'd0, 64'hB, a1);
        do_req(1'b1, 64'h60, 9'd0, 64'hC, a2);
        do_req(1'b0, 64'h50, 9'd0, 64'd0, l0);
        do_req(1'b0, 64'h58, 9'd0, 64'd0, l1);
        do_req(1'b0, 64'h60, 9'd0, 64'd0, l2);
        bus.req_valid = 1'b0;
        chk("b2b_store_gap1", 64'(a1 - a0), 64'd3);
        chk("b2b_store_gap2", 64'(a2 - a1), 64'd3);
        chk("b2b_store_load_gap", 64'(l0 - a2), 64'd3);
        chk("b2b_load_gap1", 64'(l1 - l0), 64'd4);
        chk("b2b_load_gap2", 64'(l2 - l1), 64'd4);
        drain();
        old5 = ref_mem[5];
        bus.req_is_store = 1'b1;
        bus.req_base = 64'h28;
        bus.req_offset = 9'd0;
        bus.req_wdata = ~old5;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_we", 64'(bus.MemWriteEnable), 64'd0);
        chk("rstmid_re", 64'(bus.MemReadEnable), 64'd0);
        @(negedge clk);
        check_reset();
        chk("rstmid_word5", mem_arr[5], old5);
        @(posedge clk);
        #1 rst = 1'b1;
        rnd_bp = 1'b1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int r = $urandom_range(0, 9);
                    logic [63:0] base = 64'($urandom_range(0, 80)) * 8;
                    logic [8:0] off = {6'($urandom_range(0, 63)), 3'b000};
                    if (r == 0) off[2:0] = 3'($urandom_range(1, 7));
                    if (r == 1) base = 64'hFFFF_FFFF_FFFF_FF00 + base;
                    do_req(1'($urandom_range(0, 1)), base, off, {$urandom, $urandom}, a0);
                end
                bus.req_valid = 1'b0;
                drain();
                rnd_bp = 1'b0;
            end
            while (rnd_bp) begin
                @(posedge clk);
                #1 bus.rsp_ready = $urandom_range(0, 3) != 0;
            end
        join
        bus.rsp_ready = 1'b1;
        drain();
        for (int i = 0; i < 64; i++) chk("final_mem", mem_arr[i], ref_mem[i]);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
